// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writeback requesters.
// Optional per-requester saturating grant counters are built when WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wb_hold,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  output logic [NREQ*16-1:0]       stat_grants
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  next_ptr;
  logic              hit;
  logic              active;
  int                sum;
  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Scan from the far end of the rotation back to rr_ptr so the last hit is the first in priority order.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    sum  = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      if (req_valid[PTR_W'(sum)]) begin
        hit  = 1'b1;
        gidx = PTR_W'(sum);
      end
    end
  end

  assign active   = hit & ~wb_hold & ~rst;
  assign next_ptr = (gidx == LAST) ? '0 : gidx + 1'b1;
  assign sel_addr = addr_arr[gidx];
  assign sel_data = data_arr[gidx];

  always_comb begin
    req_ready = '0;
    if (active) req_ready[gidx] = 1'b1;
  end

  // Writes to register 0 are consumed but never reach the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else if (active) begin
      rr_ptr <= next_ptr;
      if (sel_addr != '0) begin
        we    <= 1'b1;
        waddr <= sel_addr;
        wdata <= sel_data;
      end else begin
        we    <= 1'b0;
        waddr <= '0;
        wdata <= '0;
      end
    end else begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    assign stat_grants[i*16 +: 16] = grant_cnt[i];
  end
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter with NREQ=3, ADDR_W=5, DATA_W=32.
// Stats checks follow WB_ARB_STATS_EN; the default build expects stat_grants tied to zero.
module tb_regfile_wb_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wb_hold;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;
  logic [NREQ*16-1:0]     stat_grants;

  logic [ADDR_W-1:0] a [NREQ];
  logic [DATA_W-1:0] d [NREQ];
  logic [15:0]       mcnt [NREQ];
  wr_t               sb [$];
  int                checks;
  int                failures;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  regfile_wb_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .wb_hold     (wb_hold),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .stat_grants (stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ*16-1:0] expStats();
`ifdef WB_ARB_STATS_EN
    return {mcnt[2], mcnt[1], mcnt[0]};
`else
    return '0;
`endif
  endfunction

  // One cycle: drive, check the grant, queue the expected write, then check it one edge later.
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic hold,
                               input logic [NREQ-1:0] exp_ready, input string tag);
    wr_t e;
    wr_t got;
    req_valid = valid;
    wb_hold   = hold;
    #2;
    checkOutput({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    e = '0;
    for (int g = 0; g < NREQ; g++) begin
      if (exp_ready[g]) begin
        if (a[g] != '0) e = '{we: 1'b1, addr: a[g], data: d[g]};
        if (mcnt[g] != 16'hFFFF) mcnt[g] = mcnt[g] + 16'd1;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({tag, ".we"},    64'(we),    64'(got.we));
    checkOutput({tag, ".waddr"}, 64'(waddr), 64'(got.addr));
    checkOutput({tag, ".wdata"}, 64'(wdata), 64'(got.data));
    checkOutput({tag, ".stats"}, 64'(stat_grants), 64'(expStats()));
  endtask

  initial begin
    int tmp;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    wb_hold   = 1'b0;
    req_valid = 3'b111;
    a[0] = 5'd1;  a[1] = 5'd2;  a[2] = 5'd3;
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    for (int i = 0; i < NREQ; i++) mcnt[i] = '0;

    #1;
    checkOutput("reset.ready", 64'(req_ready), 64'd0);
    checkOutput("reset.we",    64'(we),        64'd0);
    checkOutput("reset.waddr", 64'(waddr),     64'd0);
    checkOutput("reset.wdata", 64'(wdata),     64'd0);
    checkOutput("reset.stats", 64'(stat_grants), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(3'b111, 1'b0, 3'b001, "fair0");
    applyStimulus(3'b111, 1'b0, 3'b010, "fair1");
    applyStimulus(3'b111, 1'b0, 3'b100, "fair2");
    applyStimulus(3'b111, 1'b0, 3'b001, "fair3");

    applyStimulus(3'b010, 1'b0, 3'b010, "skip0");
    applyStimulus(3'b010, 1'b0, 3'b010, "skip1");
    applyStimulus(3'b101, 1'b0, 3'b100, "skip2");
    applyStimulus(3'b101, 1'b0, 3'b001, "skip3");

    applyStimulus(3'b111, 1'b1, 3'b000, "hold0");
    applyStimulus(3'b111, 1'b1, 3'b000, "hold1");
    applyStimulus(3'b111, 1'b1, 3'b000, "hold2");
    applyStimulus(3'b111, 1'b0, 3'b010, "unhold");

    a[0] = 5'd0; d[0] = 32'hDEADBEEF;
    applyStimulus(3'b001, 1'b0, 3'b001, "zero");
    a[0] = 5'd1; d[0] = 32'h11;
    applyStimulus(3'b111, 1'b0, 3'b010, "zeroptr");

    a[1] = 5'd5; a[2] = 5'd5;
    applyStimulus(3'b110, 1'b0, 3'b100, "same0");
    applyStimulus(3'b110, 1'b0, 3'b010, "same1");
    a[1] = 5'd2; a[2] = 5'd3;

    req_valid = 3'b111;
    #2;
    checkOutput("midrst.ready", 64'(req_ready), 64'b100);
    @(posedge clk);
    #1;
    checkOutput("midrst.we_pend", 64'(we),    64'd1);
    checkOutput("midrst.waddr",   64'(waddr), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst.we_drop",    64'(we),        64'd0);
    checkOutput("midrst.waddr_drop", 64'(waddr),     64'd0);
    checkOutput("midrst.wdata_drop", 64'(wdata),     64'd0);
    checkOutput("midrst.ready_rst",  64'(req_ready), 64'd0);
    checkOutput("midrst.stats",      64'(stat_grants), 64'd0);
    for (int i = 0; i < NREQ; i++) mcnt[i] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(3'b111, 1'b0, 3'b001, "postrst");
    for (int i = 0; i < 5; i++) applyStimulus(3'b010, 1'b0, 3'b010, "stat5");

`ifdef WB_ARB_STATS_EN
    req_valid = 3'b010;
    repeat (65528) @(posedge clk);
    #1;
    tmp = int'(mcnt[1]) + 65528;
    mcnt[1] = (tmp > 65535) ? 16'hFFFF : tmp[15:0];
    applyStimulus(3'b010, 1'b0, 3'b010, "sat0");
    applyStimulus(3'b010, 1'b0, 3'b010, "sat1");
    applyStimulus(3'b010, 1'b0, 3'b010, "sat2");
    checkOutput("sat.final", 64'(stat_grants[31:16]), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (we/waddr/wdata) between NREQ writeback requesters, e.g. ALU, load unit and multiply/divide unit. It uses a round-robin valid/ready handshake and a registered output stage that drives the regfile write port directly. The regfile's existing write-to-read bypass still applies to the registered outputs.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_W, 5, register address width (matches RegAddrBus)
DATA_W, 32, register data width (matches RegBus)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NREQ  requester i has a pending write
req_addr  input  NREQ*ADDR_W  requester i destination, bits [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*DATA_W  requester i data, bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  one-hot grant, combinational; handshake completes when valid&ready
wb_hold  input  1  freeze the write port (pipeline stall / debug halt)
we  output  1  regfile write enable, registered
waddr  output  ADDR_W  regfile write address, registered
wdata  output  DATA_W  regfile write data, registered
stat_grants  output  NREQ*16  per-requester grant counters (see Optional Feature)

Behaviour:
- Reset (async, rst=1): we=0, waddr=0, wdata=0, rr_ptr=0, stat counters=0. req_ready=0 while rst=1.
- rr_ptr (clog2(NREQ) bits) names the highest-priority requester. Search order: rr_ptr, rr_ptr+1, ... modulo NREQ. The first requester with req_valid set is g.
- wb_hold=0 and some valid: req_ready = one-hot(g), driven the same cycle.
  - Next edge: we<=1, waddr<=req_addr[g], wdata<=req_data[g], rr_ptr<=(g+1) mod NREQ.
- Latency: exactly 1 cycle from handshake to we=1. Throughput: one write per cycle.
- No valid, or wb_hold=1: req_ready=0. Next edge: we<=0, waddr<=0, wdata<=0. rr_ptr unchanged.
- A request with req_addr[g]==0:
  - Granted and consumed normally; rr_ptr advances.
  - Next edge: we<=0, waddr<=0, wdata<=0. The zero register is never written through the port.
- Requesters hold valid/addr/data stable until ready. Deasserting valid without a handshake is legal; the arbiter has no memory of un-granted requests.
- Two requesters targeting the same address in one cycle are serialised in round-robin order. The later grant overwrites.
- NREQ not a power of two: rr_ptr wraps from NREQ-1 to 0. Values >= NREQ are unreachable.
- Reset asserted mid-stream: an in-flight registered write is dropped (we=0 immediately). Requesters must re-present.
- No combinational path from we/waddr/wdata back to req_ready.

Optional Feature:
Macro: WB_ARB_STATS_EN
- Defined:
  - One 16-bit counter per requester, incremented on each completed handshake, including addr-0 handshakes.
  - Counters saturate at 16'hFFFF and clear only on rst.
  - stat_grants slice i = counter i.
- Not defined: no counters are built and stat_grants is tied to 0.

Test Plan:
- Reset: rst=1 asynchronously mid-stream with we=1 pending -> we, waddr and wdata go to 0 before the next edge; after release the first grant goes to req 0.
- Fairness: NREQ=3, all valid continuously, addrs 1/2/3, data 0x11/0x22/0x33 -> req_ready cycles 001,010,100,001. we=1 every cycle one cycle later, with waddr 1,2,3,1.
- Pointer skip:
  - Only req1 valid for 2 cycles -> two grants to req1 and rr_ptr=2.
  - Then req0 and req2 valid -> req2 granted first, then req0.
- Hold: wb_hold=1 for 3 cycles with all valid -> req_ready=000 and we=0 during the hold, rr_ptr unchanged. After release the same requester is granted first.
- Zero register: req0 addr 0, data 0xDEADBEEF -> req_ready[0]=1, next cycle we=0 and waddr=0, rr_ptr advances to 1.
- Stats (WB_ARB_STATS_EN):
  - 5 grants to req1 -> stat_grants[31:16]=5, others 0.
  - Preload near 0xFFFF and grant twice more -> counter holds 0xFFFF.
